// File: rtl/taxi_eth_rx_enable_ctrl.sv
// Receive-enable sequencer for a GMII Ethernet receiver: waits for an idle line before
// enabling, drains an in-flight frame on disable, and keeps saturating frame/error counters.
module taxi_eth_rx_enable_ctrl #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned IDLE_CYC      = 12,
  parameter int unsigned DRAIN_TIMEOUT = 2048
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             gmii_rx_dv,

  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,

  input  logic             start_packet,
  input  logic             error_bad_frame,
  input  logic             error_bad_fcs,

  input  logic             rx_enable_req,
  input  logic             stat_clear,

  output logic             cfg_rx_enable,
  output logic             rx_active,
  output logic             frame_in_progress,
  output logic             drain_timeout,

  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_bad_frame,
  output logic [CNT_W-1:0] stat_bad_fcs
);

  localparam int unsigned IdleW  = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
  localparam int unsigned DrainW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(IDLE_CYC - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StDisabled,
    StQualify,
    StEnabled,
    StDraining
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [IdleW-1:0]  r_idle_cnt;
  logic [IdleW-1:0]  w_idle_cnt_d;
  logic [DrainW-1:0] r_drain_cnt;
  logic [DrainW-1:0] w_drain_cnt_d;
  logic              r_fip;
  logic              w_fip_d;
  logic              r_drain_timeout;
  logic              w_timeout;
  logic              w_tlast_acc;

  logic [CNT_W-1:0]  r_stat_frames;
  logic [CNT_W-1:0]  r_stat_bad_frame;
  logic [CNT_W-1:0]  r_stat_bad_fcs;

  assign w_tlast_acc = mon_tvalid & mon_tready & mon_tlast;

  always_comb begin
    w_state_d     = r_state;
    w_idle_cnt_d  = r_idle_cnt;
    w_drain_cnt_d = r_drain_cnt;
    w_timeout     = 1'b0;

    unique case (r_state)
      StDisabled: begin
        if (rx_enable_req) begin
          w_state_d    = StQualify;
          w_idle_cnt_d = '0;
        end
      end

      StQualify: begin
        if (!rx_enable_req) begin
          w_state_d = StDisabled;
        end else if (gmii_rx_dv) begin
          w_idle_cnt_d = '0;
        end else if (r_idle_cnt == IdleLast) begin
          w_state_d = StEnabled;
        end else begin
          w_idle_cnt_d = r_idle_cnt + IdleW'(1);
        end
      end

      StEnabled: begin
        if (!rx_enable_req) begin
          if (r_fip) begin
            w_state_d     = StDraining;
            w_drain_cnt_d = '0;
          end else begin
            w_state_d = StDisabled;
          end
        end
      end

      StDraining: begin
        // A re-request keeps the receiver enabled; a completed frame wins over the timeout.
        if (rx_enable_req) begin
          w_state_d = StEnabled;
        end else if (w_tlast_acc) begin
          w_state_d = StDisabled;
        end else if (r_drain_cnt == DrainLast) begin
          w_state_d = StDisabled;
          w_timeout = 1'b1;
        end else begin
          w_drain_cnt_d = r_drain_cnt + DrainW'(1);
        end
      end

      default: begin
        w_state_d = StDisabled;
      end
    endcase
  end

  // A new start overrides any clear in the same cycle, so back-to-back frames stay tracked.
  always_comb begin
    w_fip_d = r_fip;
    if (start_packet) begin
      w_fip_d = 1'b1;
    end else if (w_tlast_acc || w_timeout) begin
      w_fip_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= StDisabled;
      r_idle_cnt      <= '0;
      r_drain_cnt     <= '0;
      r_fip           <= 1'b0;
      r_drain_timeout <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_idle_cnt      <= w_idle_cnt_d;
      r_drain_cnt     <= w_drain_cnt_d;
      r_fip           <= w_fip_d;
      r_drain_timeout <= w_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      r_stat_frames    <= '0;
      r_stat_bad_frame <= '0;
      r_stat_bad_fcs   <= '0;
    end else begin
      if (w_tlast_acc && (r_stat_frames != '1)) begin
        r_stat_frames <= r_stat_frames + CNT_W'(1);
      end
      if (error_bad_frame && (r_stat_bad_frame != '1)) begin
        r_stat_bad_frame <= r_stat_bad_frame + CNT_W'(1);
      end
      if (error_bad_fcs && (r_stat_bad_fcs != '1)) begin
        r_stat_bad_fcs <= r_stat_bad_fcs + CNT_W'(1);
      end
    end
  end

  assign cfg_rx_enable     = (r_state == StEnabled) || (r_state == StDraining);
  assign rx_active         = (r_state == StEnabled);
  assign frame_in_progress = r_fip;
  assign drain_timeout     = r_drain_timeout;
  assign stat_frames       = r_stat_frames;
  assign stat_bad_frame    = r_stat_bad_frame;
  assign stat_bad_fcs      = r_stat_bad_fcs;

endmodule

// File: tb/tb_taxi_eth_rx_enable_ctrl.sv
// Self-checking bench for taxi_eth_rx_enable_ctrl: two instances sharing stimulus, one with a
// long drain window (graceful drain) and one with a 16-cycle window (timeout behaviour).
module tb_taxi_eth_rx_enable_ctrl;

  localparam int unsigned CntW    = 4;
  localparam int unsigned IdleCyc = 12;
  localparam int          CntMax  = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst, dv, tvalid, tready, tlast, sp, ebf, efcs, req, sclr;

  logic            a_cfg, a_act, a_fip, a_dto;
  logic [CntW-1:0] a_frames, a_bad_frame, a_bad_fcs;
  logic            b_cfg, b_act, b_fip, b_dto;
  logic [CntW-1:0] b_frames, b_bad_frame, b_bad_fcs;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  taxi_eth_rx_enable_ctrl #(
    .CNT_W        (CntW),
    .IDLE_CYC     (IdleCyc),
    .DRAIN_TIMEOUT(64)
  ) u_dut_a (
    .clk              (clk),
    .rst              (rst),
    .gmii_rx_dv       (dv),
    .mon_tvalid       (tvalid),
    .mon_tready       (tready),
    .mon_tlast        (tlast),
    .start_packet     (sp),
    .error_bad_frame  (ebf),
    .error_bad_fcs    (efcs),
    .rx_enable_req    (req),
    .stat_clear       (sclr),
    .cfg_rx_enable    (a_cfg),
    .rx_active        (a_act),
    .frame_in_progress(a_fip),
    .drain_timeout    (a_dto),
    .stat_frames      (a_frames),
    .stat_bad_frame   (a_bad_frame),
    .stat_bad_fcs     (a_bad_fcs)
  );

  taxi_eth_rx_enable_ctrl #(
    .CNT_W        (CntW),
    .IDLE_CYC     (IdleCyc),
    .DRAIN_TIMEOUT(16)
  ) u_dut_b (
    .clk              (clk),
    .rst              (rst),
    .gmii_rx_dv       (dv),
    .mon_tvalid       (tvalid),
    .mon_tready       (tready),
    .mon_tlast        (tlast),
    .start_packet     (sp),
    .error_bad_frame  (ebf),
    .error_bad_fcs    (efcs),
    .rx_enable_req    (req),
    .stat_clear       (sclr),
    .cfg_rx_enable    (b_cfg),
    .rx_active        (b_act),
    .frame_in_progress(b_fip),
    .drain_timeout    (b_dto),
    .stat_frames      (b_frames),
    .stat_bad_frame   (b_bad_frame),
    .stat_bad_fcs     (b_bad_fcs)
  );

  // Inputs change 1 ns after a rising edge and outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dv = 0; tvalid = 0; tready = 0; tlast = 0; sp = 0; ebf = 0; efcs = 0; req = 0; sclr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Enable over an idle line, start a frame, then drop the request: both instances drain.
  task automatic enter_drain();
    req = 1;
    dv  = 0;
    repeat (IdleCyc + 1) tick();
    sp = 1;
    tick();
    sp  = 0;
    req = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; req = 1; sp = 1; efcs = 1; ebf = 1; tvalid = 1; tready = 1; tlast = 1;
    dv = 1'($urandom_range(0, 1));
    tick();
    tick();
    n_total++;
    if ({a_cfg, a_act, a_fip, a_dto, b_cfg, b_act, b_fip, b_dto} !== 8'h00) begin
      $display("FAIL reset_flags got a=%b%b%b%b b=%b%b%b%b want all 0",
               a_cfg, a_act, a_fip, a_dto, b_cfg, b_act, b_fip, b_dto);
    end else n_pass++;
    n_total++;
    if ({a_frames, a_bad_frame, a_bad_fcs} !== '0) begin
      $display("FAIL reset_counters got %0d %0d %0d want 0 0 0",
               a_frames, a_bad_frame, a_bad_fcs);
    end else n_pass++;
    rst = 0;
    clear_inputs();
  endtask

  // Request sampled at edge 0 with an idle line: enabled after edge IdleCyc, and a reset
  // in the middle of qualification restarts the whole window.
  task automatic test_enable_latency();
    do_reset();
    req = 1;
    for (int i = 0; i <= IdleCyc + 2; i++) begin
      tick();
      n_total++;
      if (a_cfg !== (i >= IdleCyc)) begin
        $display("FAIL enable_latency edge %0d cfg_rx_enable got %b want %b",
                 i, a_cfg, (i >= IdleCyc));
      end else n_pass++;
      if (i == IdleCyc) begin
        n_total++;
        if (a_act !== 1'b1) $display("FAIL enable_active got %b want 1", a_act);
        else n_pass++;
      end
    end
    do_reset();
    req = 1;
    repeat (7) tick();
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i <= IdleCyc + 1; i++) begin
      tick();
      n_total++;
      if (a_cfg !== (i >= IdleCyc)) begin
        $display("FAIL requalify edge %0d cfg_rx_enable got %b want %b",
                 i, a_cfg, (i >= IdleCyc));
      end else n_pass++;
    end
  endtask

  // Random busy line during qualification; expected enable edge comes from the run length
  // of consecutive dv-low cycles.
  task automatic test_busy_line();
    for (int it = 0; it < 4; it++) begin
      bit pat [0:40];
      int run;
      int en_edge;
      for (int i = 0; i <= 40; i++) pat[i] = (i < 24) && ($urandom_range(0, 3) == 0);
      pat[10] = 1'b1;
      run     = 0;
      en_edge = -1;
      for (int i = 1; i <= 40; i++) begin
        run = pat[i] ? 0 : run + 1;
        if (run == IdleCyc && en_edge < 0) en_edge = i;
      end
      do_reset();
      req = 1;
      for (int i = 0; i <= 40; i++) begin
        dv = pat[i];
        tick();
        n_total++;
        if (a_cfg !== (en_edge >= 0 && i >= en_edge)) begin
          $display("FAIL busy_line iter %0d edge %0d cfg_rx_enable got %b want %b",
                   it, i, a_cfg, (en_edge >= 0 && i >= en_edge));
        end else n_pass++;
      end
      dv = 0;
    end
  endtask

  task automatic test_graceful_drain();
    bit saw_dto;
    do_reset();
    enter_drain();
    n_total++;
    if ({a_cfg, a_act, a_fip} !== 3'b101) begin
      $display("FAIL drain_entry cfg/act/fip got %b%b%b want 101", a_cfg, a_act, a_fip);
    end else n_pass++;
    req = 1;
    tick();
    n_total++;
    if ({a_cfg, a_act} !== 2'b11) begin
      $display("FAIL drain_resume cfg/act got %b%b want 11", a_cfg, a_act);
    end else n_pass++;
    req = 0;
    tick();
    n_total++;
    if ({a_cfg, a_act, a_fip} !== 3'b101) begin
      $display("FAIL drain_reentry cfg/act/fip got %b%b%b want 101", a_cfg, a_act, a_fip);
    end else n_pass++;
    saw_dto = 0;
    repeat (49) begin
      tick();
      saw_dto |= a_dto;
    end
    n_total++;
    if (a_cfg !== 1'b1) $display("FAIL drain_hold cfg_rx_enable got %b want 1", a_cfg);
    else n_pass++;
    tvalid = 1; tready = 1; tlast = 1;
    tick();
    tvalid = 0; tready = 0; tlast = 0;
    saw_dto |= a_dto;
    n_total++;
    if ({a_cfg, a_fip} !== 2'b00) begin
      $display("FAIL drain_done cfg/fip got %b%b want 00", a_cfg, a_fip);
    end else n_pass++;
    n_total++;
    if (a_frames !== 4'd1) $display("FAIL drain_frames got %0d want 1", a_frames);
    else n_pass++;
    n_total++;
    if (saw_dto !== 1'b0) $display("FAIL drain_no_timeout got %b want 0", saw_dto);
    else n_pass++;
  endtask

  task automatic test_drain_timeout();
    int pulses;
    do_reset();
    enter_drain();
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      pulses += int'(b_dto);
      n_total++;
      if ({b_dto, b_cfg} !== {1'(i == 16), 1'(i < 16)}) begin
        $display("FAIL timeout edge %0d dto/cfg got %b%b want %b%b",
                 i, b_dto, b_cfg, (i == 16), (i < 16));
      end else n_pass++;
      if (i == 16) begin
        n_total++;
        if (b_fip !== 1'b0) $display("FAIL timeout_fip got %b want 0", b_fip);
        else n_pass++;
      end
    end
    n_total++;
    if (pulses != 1) $display("FAIL timeout_pulse_count got %0d want 1", pulses);
    else n_pass++;

    // tlast on the final drain cycle completes the frame instead of timing out
    do_reset();
    enter_drain();
    repeat (15) tick();
    tvalid = 1; tready = 1; tlast = 1;
    tick();
    tvalid = 0; tready = 0; tlast = 0;
    n_total++;
    if ({b_dto, b_cfg, b_fip} !== 3'b000) begin
      $display("FAIL tie_tlast dto/cfg/fip got %b%b%b want 000", b_dto, b_cfg, b_fip);
    end else n_pass++;
    n_total++;
    if (b_frames !== 4'd1) $display("FAIL tie_frames got %0d want 1", b_frames);
    else n_pass++;
    tick();
    n_total++;
    if (b_dto !== 1'b0) $display("FAIL tie_late_dto got %b want 0", b_dto);
    else n_pass++;
  endtask

  task automatic test_saturation_clear();
    do_reset();
    efcs = 1;
    repeat (17) tick();
    n_total++;
    if (a_bad_fcs !== 4'd15) $display("FAIL sat_bad_fcs got %0d want 15", a_bad_fcs);
    else n_pass++;
    sclr = 1;
    tick();
    sclr = 0;
    efcs = 0;
    n_total++;
    if (a_bad_fcs !== 4'd0) $display("FAIL clear_wins got %0d want 0", a_bad_fcs);
    else n_pass++;
  endtask

  // Random status traffic while disabled; counters and frame tracking modelled as integers.
  task automatic test_counters_random();
    int  m_frames, m_bad_frame, m_bad_fcs;
    bit  m_fip, acc;
    do_reset();
    m_frames = 0; m_bad_frame = 0; m_bad_fcs = 0; m_fip = 0;
    for (int i = 0; i < 300; i++) begin
      ebf    = ($urandom_range(0, 2) == 0);
      efcs   = ($urandom_range(0, 2) == 0);
      tvalid = 1'($urandom_range(0, 1));
      tready = 1'($urandom_range(0, 1));
      tlast  = 1'($urandom_range(0, 1));
      sp     = ($urandom_range(0, 3) == 0);
      sclr   = ($urandom_range(0, 39) == 0);
      acc    = tvalid && tready && tlast;
      if (sclr) begin
        m_frames = 0; m_bad_frame = 0; m_bad_fcs = 0;
      end else begin
        if (acc && m_frames < CntMax) m_frames++;
        if (ebf && m_bad_frame < CntMax) m_bad_frame++;
        if (efcs && m_bad_fcs < CntMax) m_bad_fcs++;
      end
      if (sp) m_fip = 1;
      else if (acc) m_fip = 0;
      tick();
      n_total++;
      if ({a_frames, a_bad_frame, a_bad_fcs, a_fip} !==
          {4'(m_frames), 4'(m_bad_frame), 4'(m_bad_fcs), m_fip}) begin
        $display("FAIL counters cycle %0d got fr=%0d bf=%0d fcs=%0d fip=%b want %0d %0d %0d %b",
                 i, a_frames, a_bad_frame, a_bad_fcs, a_fip,
                 m_frames, m_bad_frame, m_bad_fcs, m_fip);
      end else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    enter_drain();
    repeat (5) tick();
    rst = 1;
    req = 1;
    tick();
    n_total++;
    if ({a_cfg, a_act, a_fip, a_dto} !== 4'b0000) begin
      $display("FAIL rst_mid_drain cfg/act/fip/dto got %b%b%b%b want 0000",
               a_cfg, a_act, a_fip, a_dto);
    end else n_pass++;
    rst = 0;
    for (int i = 0; i <= IdleCyc + 1; i++) begin
      tick();
      n_total++;
      if (a_cfg !== (i >= IdleCyc)) begin
        $display("FAIL rst_reenable edge %0d cfg_rx_enable got %b want %b",
                 i, a_cfg, (i >= IdleCyc));
      end else n_pass++;
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_enable_latency();
    test_busy_line();
    test_graceful_drain();
    test_drain_timeout();
    test_saturation_clear();
    test_counters_random();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
